spigot_e_seq: RTL and testbench

- Controller that sequences the spigot computation of e's decimal digits for the top-level TinyTapeout design.
- Owns the remainder array through an external single-port RAM interface and an iterative divider (sub-module).
- Streams digits "2" then fractional digits out over a valid/ready handshake.
- Per digit: carry=0; for i=N_TERMS downto 2: x=10*a[i]+carry; a[i]=x mod i; carry=x div i. The digit is the final carry.

---
 rtl/spigot_e_pkg.sv | 30 +++
 rtl/spigot_e_divu.sv | 78 +++++++
 rtl/spigot_e_seq.sv | 203 ++++++++++++++++++++
 tb/tb_spigot_e_seq.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/spigot_e_pkg.sv
// Shared types and constants for the e-digit spigot sequencer.
// The digit encoding helper honours SPIGOT_E_ASCII_EN (ASCII when defined, BCD otherwise).
package spigot_e_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        INIT = 3'd1,
        EMIT = 3'd2,
        RD   = 3'd3,
        WAIT = 3'd4,
        DIV  = 3'd5,
        WR   = 3'd6,
        FIN  = 3'd7
    } state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [3:0] INT_DIGIT  = 4'd2;

    // Maps a decimal value 0..9 onto the byte presented on the digit port.
    function automatic logic [7:0] encode_digit(input logic [3:0] value);
        logic [7:0] enc_s;
`ifdef SPIGOT_E_ASCII_EN
        enc_s = ASCII_ZERO + {4'b0000, value};
`else
        enc_s = {4'b0000, value};
`endif
        return enc_s;
    endfunction

endpackage

// File: rtl/spigot_e_divu.sv
// Restoring unsigned divider: X_W-bit dividend by ADDR_W-bit divisor, one quotient bit per cycle.
// done pulses once, X_W cycles after start was sampled; quotient/remainder hold until the next start.
module spigot_e_divu #(
    parameter int X_W    = 10,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [X_W-1:0]    dividend,
    input  logic [ADDR_W-1:0] divisor,
    output logic              done,
    output logic [X_W-1:0]    quotient,
    output logic [ADDR_W-1:0] remainder
);

    localparam int CNT_W = $clog2(X_W + 1);

    logic [CNT_W-1:0]  cnt_r;
    logic              busy_r;
    logic              done_r;
    logic [ADDR_W-1:0] div_r;
    logic [ADDR_W-1:0] rem_r;
    logic [X_W-1:0]    quo_r;

    logic [ADDR_W:0]   shifted_s;
    logic [ADDR_W:0]   diff_s;
    logic              ge_s;
    logic [ADDR_W-1:0] rem_nxt_s;

    // Trial subtraction for the current quotient bit.
    always_comb begin
        shifted_s = {rem_r, quo_r[X_W-1]};
        diff_s    = shifted_s - {1'b0, div_r};
        ge_s      = (shifted_s >= {1'b0, div_r});
        if (ge_s) begin
            rem_nxt_s = ADDR_W'(diff_s);
        end else begin
            rem_nxt_s = ADDR_W'(shifted_s);
        end
    end

    // Iteration registers; the dividend register doubles as the quotient shift register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            div_r  <= '0;
            rem_r  <= '0;
            quo_r  <= '0;
        end else if (start) begin
            cnt_r  <= CNT_W'(X_W);
            busy_r <= 1'b1;
            done_r <= 1'b0;
            div_r  <= divisor;
            rem_r  <= '0;
            quo_r  <= dividend;
        end else if (busy_r) begin
            quo_r <= {quo_r[X_W-2:0], ge_s};
            rem_r <= rem_nxt_s;
            cnt_r <= cnt_r - CNT_W'(1);
            if (cnt_r == CNT_W'(1)) begin
                busy_r <= 1'b0;
                done_r <= 1'b1;
            end else begin
                done_r <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign done      = done_r;
    assign quotient  = quo_r;
    assign remainder = rem_r;

endmodule

// File: rtl/spigot_e_seq.sv
// Sequencer streaming e's decimal digits via the spigot algorithm over an external single-port RAM.
// Digit encoding is ASCII when SPIGOT_E_ASCII_EN is defined, BCD in the low nibble otherwise.
module spigot_e_seq
    import spigot_e_pkg::*;
#(
    parameter int N_TERMS = 64,
    parameter int ADDR_W  = 7,
    parameter int REM_W   = 7,
    parameter int X_W     = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        num_digits,
    output logic              busy,
    output logic              done,
    output logic [7:0]        digit,
    output logic              digit_valid,
    input  logic              digit_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [REM_W-1:0]  mem_wdata,
    input  logic [REM_W-1:0]  mem_rdata
);

    state_t            state_r,  state_nxt_s;
    logic [ADDR_W-1:0] idx_r,    idx_nxt_s;
    logic [3:0]        carry_r,  carry_nxt_s;
    logic [7:0]        frac_r,   frac_nxt_s;
    logic [7:0]        num_r,    num_nxt_s;
    logic              busy_r,   busy_nxt_s;
    logic              done_r,   done_nxt_s;
    logic [7:0]        digit_r,  digit_nxt_s;
    logic              valid_r,  valid_nxt_s;
    logic [ADDR_W-1:0] addr_r,   addr_nxt_s;
    logic              we_r,     we_nxt_s;
    logic [REM_W-1:0]  wdata_r,  wdata_nxt_s;

    logic              div_start_s;
    logic              div_done_s;
    logic [X_W-1:0]    div_quo_s;
    logic [ADDR_W-1:0] div_rem_s;
    logic [X_W-1:0]    x_s;

    // 10*a + carry built as 8a + 2a + carry.
    assign x_s = X_W'({mem_rdata, 3'b000}) + X_W'({mem_rdata, 1'b0}) + X_W'(carry_r);

    spigot_e_divu #(
        .X_W    (X_W),
        .ADDR_W (ADDR_W)
    ) u_divu (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start_s),
        .dividend  (x_s),
        .divisor   (idx_r),
        .done      (div_done_s),
        .quotient  (div_quo_s),
        .remainder (div_rem_s)
    );

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        carry_nxt_s = carry_r;
        frac_nxt_s  = frac_r;
        num_nxt_s   = num_r;
        busy_nxt_s  = busy_r;
        done_nxt_s  = 1'b0;
        digit_nxt_s = digit_r;
        valid_nxt_s = valid_r;
        addr_nxt_s  = addr_r;
        we_nxt_s    = 1'b0;
        wdata_nxt_s = wdata_r;
        div_start_s = 1'b0;

        case (state_r)
            IDLE: begin
                if (start) begin
                    num_nxt_s   = num_digits;
                    busy_nxt_s  = 1'b1;
                    frac_nxt_s  = 8'd0;
                    idx_nxt_s   = ADDR_W'(2);
                    addr_nxt_s  = ADDR_W'(2);
                    we_nxt_s    = 1'b1;
                    wdata_nxt_s = REM_W'(1);
                    state_nxt_s = INIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            INIT: begin
                if (idx_r == ADDR_W'(N_TERMS)) begin
                    digit_nxt_s = encode_digit(INT_DIGIT);
                    valid_nxt_s = 1'b1;
                    state_nxt_s = EMIT;
                end else begin
                    idx_nxt_s   = idx_r + ADDR_W'(1);
                    addr_nxt_s  = idx_r + ADDR_W'(1);
                    we_nxt_s    = 1'b1;
                    wdata_nxt_s = REM_W'(1);
                end
            end
            EMIT: begin
                if (digit_ready) begin
                    valid_nxt_s = 1'b0;
                    if (frac_r == num_r) begin
                        done_nxt_s  = 1'b1;
                        state_nxt_s = FIN;
                    end else begin
                        carry_nxt_s = 4'd0;
                        idx_nxt_s   = ADDR_W'(N_TERMS);
                        addr_nxt_s  = ADDR_W'(N_TERMS);
                        state_nxt_s = RD;
                    end
                end else begin
                    state_nxt_s = EMIT;
                end
            end
            RD: begin
                state_nxt_s = WAIT;
            end
            WAIT: begin
                div_start_s = 1'b1;
                state_nxt_s = DIV;
            end
            DIV: begin
                if (div_done_s) begin
                    carry_nxt_s = 4'(div_quo_s);
                    addr_nxt_s  = idx_r;
                    we_nxt_s    = 1'b1;
                    wdata_nxt_s = REM_W'(div_rem_s);
                    state_nxt_s = WR;
                end else begin
                    state_nxt_s = DIV;
                end
            end
            WR: begin
                // The write is on the bus this cycle; the final carry is the digit.
                if (idx_r == ADDR_W'(2)) begin
                    digit_nxt_s = encode_digit(carry_r);
                    valid_nxt_s = 1'b1;
                    frac_nxt_s  = frac_r + 8'd1;
                    state_nxt_s = EMIT;
                end else begin
                    idx_nxt_s   = idx_r - ADDR_W'(1);
                    addr_nxt_s  = idx_r - ADDR_W'(1);
                    state_nxt_s = RD;
                end
            end
            FIN: begin
                busy_nxt_s  = 1'b0;
                state_nxt_s = IDLE;
            end
            default: begin
                busy_nxt_s  = 1'b0;
                valid_nxt_s = 1'b0;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            idx_r   <= '0;
            carry_r <= 4'd0;
            frac_r  <= 8'd0;
            num_r   <= 8'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            digit_r <= 8'd0;
            valid_r <= 1'b0;
            addr_r  <= '0;
            we_r    <= 1'b0;
            wdata_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            carry_r <= carry_nxt_s;
            frac_r  <= frac_nxt_s;
            num_r   <= num_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
            digit_r <= digit_nxt_s;
            valid_r <= valid_nxt_s;
            addr_r  <= addr_nxt_s;
            we_r    <= we_nxt_s;
            wdata_r <= wdata_nxt_s;
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign digit       = digit_r;
    assign digit_valid = valid_r;
    assign mem_addr    = addr_r;
    assign mem_we      = we_r;
    assign mem_wdata   = wdata_r;

endmodule

// File: tb/tb_spigot_e_seq.sv
// Self-checking bench for spigot_e_seq: expected digits come from a stored decimal expansion of e,
// queued at start and popped on each digit handshake.
module tb_spigot_e_seq;

    localparam int ADDR_W = 7;
    localparam int REM_W  = 7;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [7:0]        num_digits;
    logic              busy;
    logic              done;
    logic [7:0]        digit;
    logic              digit_valid;
    logic              digit_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [REM_W-1:0]  mem_wdata;
    logic [REM_W-1:0]  mem_rdata;

    logic [REM_W-1:0]  ram [0:(1<<ADDR_W)-1];

    int         total;
    int         bad;
    logic [7:0] exp_q[$];
    string      golden;

    spigot_e_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .num_digits  (num_digits),
        .busy        (busy),
        .done        (done),
        .digit       (digit),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM with one-cycle registered read.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    function automatic logic [7:0] enc(input logic [7:0] v);
`ifdef SPIGOT_E_ASCII_EN
        return 8'h30 + v;
`else
        return v;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_run(input int n);
        for (int i = 0; i <= n; i++) begin
            logic [7:0] g;
            g = golden[i];
            exp_q.push_back(enc(g - 8'h30));
        end
    endtask

    task automatic do_start(input int n);
        @(negedge clk);
        num_digits = 8'(n);
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_valid(input int max_cyc);
        for (int c = 0; c < max_cyc && !digit_valid; c++) @(negedge clk);
        check("valid_seen", digit_valid, 1);
    endtask

    // Drives digit_ready with the given percentage and scores every handshake.
    task automatic collect(input int ready_pct, input int stop_after, input int max_cyc);
        int         got;
        bit         fin;
        bit         xfer_prev;
        bit         hold_prev;
        logic [7:0] prev_digit;
        logic [7:0] e;
        got = 0; fin = 0; xfer_prev = 0; hold_prev = 0; prev_digit = 8'd0;
        for (int c = 0; c < max_cyc && !fin; c++) begin
            @(negedge clk);
            if (done) begin
                check("done_after_last_xfer", xfer_prev, 1);
                check("queue_empty_at_done", exp_q.size(), 0);
                check("busy_with_done", busy, 1);
                fin = 1;
            end else begin
                if (xfer_prev) check("valid_drop_after_xfer", digit_valid, 0);
                if (hold_prev) begin
                    check("valid_held", digit_valid, 1);
                    check("digit_stable", digit, prev_digit);
                end
                digit_ready = ($urandom_range(99) < ready_pct);
                hold_prev   = digit_valid && !digit_ready;
                xfer_prev   = digit_valid && digit_ready;
                prev_digit  = digit;
                if (xfer_prev) begin
                    if (exp_q.size() == 0) begin
                        check("extra_digit", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("digit", digit, e);
                    end
                    got++;
                    if (stop_after > 0 && got == stop_after) fin = 1;
                end
            end
        end
        check("run_completed", fin, 1);
        if (stop_after == 0) begin
            @(negedge clk);
            check("busy_clear_after_done", busy, 0);
            check("done_single_pulse", done, 0);
        end
    endtask

    initial begin
        golden = "27182818284590452353602874713526624977572470936999595749669676277240766303535475945713821785251664274";
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        digit_ready = 1'b0;
        num_digits  = 8'd0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", digit_valid, 0);
        check("rst_we", mem_we, 0);
        check("rst_digit", digit, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        rst_n = 1'b1;

        // Golden run, 80 fractional digits, consumer always ready
        push_run(80);
        do_start(80);
        collect(100, 0, 80000);

        // num_digits = 0: only the integer digit
        push_run(0);
        do_start(0);
        collect(100, 0, 500);

        // Backpressure with sparse ready
        push_run(5);
        do_start(5);
        collect(30, 0, 12000);

        // Start while busy is ignored; stall in EMIT does no RAM traffic
        push_run(4);
        digit_ready = 1'b0;
        do_start(4);
        repeat (20) @(negedge clk);
        check("busy_during_init", busy, 1);
        do_start(2);
        wait_valid(2000);
        repeat (20) begin
            @(negedge clk);
            check("stall_no_write", mem_we, 0);
            check("stall_valid", digit_valid, 1);
            check("stall_digit", digit, exp_q[0]);
        end
        collect(100, 0, 8000);

        // Reset during the third digit's divide, then restart
        push_run(10);
        do_start(10);
        collect(100, 2, 5000);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_valid", digit_valid, 0);
        check("midrst_we", mem_we, 0);
        check("midrst_digit", digit, 0);
        check("midrst_addr", mem_addr, 0);
        rst_n = 1'b1;
        exp_q.delete();
        push_run(3);
        do_start(3);
        collect(100, 0, 5000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
